// File: rtl/dcache_pkg.sv
// Shared types and constants for the write-through data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        RESP   = 2'd2,
        WRITE  = 2'd3
    } state_t;

    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BYTE = 3'b100;

    localparam int OFF_W = 2;

    // Index width for a power-of-two count, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU-side and backing-memory-side bundles of the data cache.
interface dcache_cpu_if #(parameter int ADDR_W = 32);
    logic              req_i;
    logic              we_i;
    logic [ADDR_W-1:0] addr_i;
    logic [31:0]       wdata_i;
    logic [2:0]        funct3_i;
    logic [31:0]       rdata_o;
    logic              stall_o;

    modport master (output req_i, we_i, addr_i, wdata_i, funct3_i,
                    input  rdata_o, stall_o);
    modport slave  (input  req_i, we_i, addr_i, wdata_i, funct3_i,
                    output rdata_o, stall_o);
endinterface

interface dcache_mem_if #(parameter int ADDR_W = 32);
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [3:0]        mem_be_o;
    logic              mem_ack_i;
    logic [31:0]       mem_rdata_i;

    modport master (output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
                    input  mem_ack_i, mem_rdata_i);
    modport slave  (input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
                    output mem_ack_i, mem_rdata_i);
endinterface

// File: rtl/dcache_store_align.sv
// Byte-enable / lane replication for stores and byte extraction for loads.
module dcache_store_align
    import dcache_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wlanes_o,
    output logic [31:0] rdata_o
);

    // Anything other than the byte code behaves as a full word access.
    always_comb begin
        be_o     = 4'b1111;
        wlanes_o = wdata_i;
        rdata_o  = rword_i;
        if (funct3_i == F3_BYTE) begin
            be_o     = 4'b0001 << offset_i;
            wlanes_o = {4{wdata_i[7:0]}};
            case (offset_i)
                2'd0:    rdata_o = {24'h000000, rword_i[7:0]};
                2'd1:    rdata_o = {24'h000000, rword_i[15:8]};
                2'd2:    rdata_o = {24'h000000, rword_i[23:16]};
                2'd3:    rdata_o = {24'h000000, rword_i[31:24]};
                default: rdata_o = 32'h00000000;
            endcase
        end else begin
            be_o     = 4'b1111;
            wlanes_o = wdata_i;
            rdata_o  = rword_i;
        end
    end

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with
// zero-latency load hits and a stalling refill / write-through engine.
module dcache_wt
    import dcache_pkg::*;
#(
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    dcache_cpu_if.slave  cpu,
    dcache_mem_if.master mem
);

    localparam int WI_W  = idx_w(LINE_WORDS);
    localparam int SI_W  = idx_w(SETS);
    localparam int TAG_W = ADDR_W - OFF_W - WI_W - SI_W;
    localparam int DEPTH = SETS * LINE_WORDS;
    localparam logic [WI_W-1:0] LAST_WORD = WI_W'(LINE_WORDS - 1);

    state_t            state_r;
    logic [WI_W-1:0]   cnt_r;
    logic [SETS-1:0]   valid_r;
    logic [TAG_W-1:0]  tag_r [SETS];
    logic [31:0]       data_r [DEPTH];
    logic              mem_req_r;
    logic              mem_we_r;

    logic [WI_W-1:0]   word_s;
    logic [SI_W-1:0]   set_s;
    logic [TAG_W-1:0]  tag_s;
    logic              hit_s;
    logic [31:0]       cache_word_s;
    logic [3:0]        be_s;
    logic [31:0]       lanes_s;
    logic [31:0]       load_s;
    logic              stall_s;
    logic [31:0]       rdata_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic              refill_ack_s;
    logic              refill_done_s;
    logic              write_ack_s;

    function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                               input logic [31:0] lanes,
                                               input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = be[b] ? lanes[8*b +: 8] : old_word[8*b +: 8];
        end
        return res;
    endfunction

    assign word_s        = cpu.addr_i[OFF_W +: WI_W];
    assign set_s         = cpu.addr_i[OFF_W + WI_W +: SI_W];
    assign tag_s         = cpu.addr_i[ADDR_W-1 -: TAG_W];
    assign hit_s         = cpu.req_i & valid_r[set_s] & (tag_r[set_s] == tag_s);
    assign cache_word_s  = data_r[{set_s, word_s}];
    assign refill_ack_s  = (state_r == REFILL) & mem.mem_ack_i;
    assign refill_done_s = refill_ack_s & (cnt_r == LAST_WORD);
    assign write_ack_s   = (state_r == WRITE) & mem.mem_ack_i;

    dcache_store_align u_align (
        .funct3_i (cpu.funct3_i),
        .offset_i (cpu.addr_i[1:0]),
        .wdata_i  (cpu.wdata_i),
        .rword_i  (cache_word_s),
        .be_o     (be_s),
        .wlanes_o (lanes_s),
        .rdata_o  (load_s)
    );

    // CPU-facing stall and load data; hits answer in the request cycle.
    always_comb begin
        stall_s = 1'b0;
        rdata_s = 32'h00000000;
        case (state_r)
            IDLE: begin
                if (cpu.req_i) begin
                    stall_s = cpu.we_i | ~hit_s;
                end else begin
                    stall_s = 1'b0;
                end
                if (hit_s & ~cpu.we_i) begin
                    rdata_s = load_s;
                end else begin
                    rdata_s = 32'h00000000;
                end
            end
            RESP: begin
                stall_s = 1'b0;
                if (hit_s & ~cpu.we_i) begin
                    rdata_s = load_s;
                end else begin
                    rdata_s = 32'h00000000;
                end
            end
            REFILL:  stall_s = 1'b1;
            WRITE:   stall_s = ~mem.mem_ack_i;
            default: stall_s = 1'b0;
        endcase
    end

    // Refill beats walk the line from word 0; writes go to the word-aligned CPU address.
    always_comb begin
        if (state_r == REFILL) begin
            mem_addr_s = {tag_s, set_s, cnt_r, 2'b00};
        end else begin
            mem_addr_s = {cpu.addr_i[ADDR_W-1:OFF_W], 2'b00};
        end
    end

    assign cpu.stall_o     = rst_ni & stall_s;
    assign cpu.rdata_o     = rdata_s;
    assign mem.mem_req_o   = mem_req_r;
    assign mem.mem_we_o    = mem_we_r;
    assign mem.mem_addr_o  = mem_addr_s;
    assign mem.mem_wdata_o = lanes_s;
    assign mem.mem_be_o    = be_s;

    // Control FSM: state, refill counter, valid bits and backing-bus strobes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            valid_r   <= '0;
            mem_req_r <= 1'b0;
            mem_we_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cpu.req_i && cpu.we_i) begin
                        state_r   <= WRITE;
                        mem_req_r <= 1'b1;
                        mem_we_r  <= 1'b1;
                    end else if (cpu.req_i && !hit_s) begin
                        // The victim line is invalid until its last beat lands.
                        state_r        <= REFILL;
                        cnt_r          <= '0;
                        valid_r[set_s] <= 1'b0;
                        mem_req_r      <= 1'b1;
                        mem_we_r       <= 1'b0;
                    end
                end
                REFILL: begin
                    if (refill_ack_s) begin
                        cnt_r <= cnt_r + WI_W'(1);
                    end
                    if (refill_done_s) begin
                        valid_r[set_s] <= 1'b1;
                        cnt_r          <= '0;
                        mem_req_r      <= 1'b0;
                        state_r        <= RESP;
                    end
                end
                RESP: state_r <= IDLE;
                WRITE: begin
                    if (write_ack_s) begin
                        mem_req_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    mem_req_r <= 1'b0;
                    mem_we_r  <= 1'b0;
                end
            endcase
        end
    end

    // Tag and data arrays; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk_i) begin
        if (refill_ack_s) begin
            data_r[{set_s, cnt_r}] <= mem.mem_rdata_i;
        end else if (write_ack_s && hit_s) begin
            data_r[{set_s, word_s}] <= merge_word(cache_word_s, lanes_s, be_s);
        end
        if (refill_done_s) begin
            tag_r[set_s] <= tag_s;
        end
    end

endmodule

// File: tb/tb_dcache_wt.sv
// Directed self-checking bench for dcache_wt with a fixed-latency backing memory.
module tb_dcache_wt;
    import dcache_pkg::*;

    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst_ni;
    always #5 clk = ~clk;

    dcache_cpu_if #(.ADDR_W(32)) cpu_bus ();
    dcache_mem_if #(.ADDR_W(32)) mem_bus ();

    dcache_wt #(.SETS(16), .LINE_WORDS(4), .ADDR_W(32)) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .cpu   (cpu_bus.slave),
        .mem   (mem_bus.master)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem_q [logic [31:0]];
    logic [31:0] ack_addr_q [$];
    int          wr_cnt;
    logic [3:0]  last_be;
    logic [31:0] last_wdata;
    int          lat_cnt;
    logic [31:0] mdl_a;
    logic [31:0] mdl_w;

    logic [31:0] acc_rdata;
    int          acc_stalled;

    // Backing memory: acks each request LAT falling edges after it appears.
    always @(negedge clk) begin
        if (!rst_ni) begin
            mem_bus.mem_ack_i = 1'b0;
            lat_cnt = 0;
        end else if (mem_bus.mem_ack_i) begin
            mem_bus.mem_ack_i = 1'b0;
            lat_cnt = 0;
        end else if (mem_bus.mem_req_o) begin
            if (lat_cnt == LAT - 1) begin
                mdl_a = mem_bus.mem_addr_o;
                mdl_w = mem_q.exists(mdl_a) ? mem_q[mdl_a] : 32'h00000000;
                mem_bus.mem_ack_i = 1'b1;
                ack_addr_q.push_back(mdl_a);
                if (mem_bus.mem_we_o) begin
                    wr_cnt++;
                    last_be    = mem_bus.mem_be_o;
                    last_wdata = mem_bus.mem_wdata_o;
                    for (int b = 0; b < 4; b++) begin
                        if (last_be[b]) mdl_w[8*b +: 8] = last_wdata[8*b +: 8];
                    end
                    mem_q[mdl_a] = mdl_w;
                end else begin
                    mem_bus.mem_rdata_i = mdl_w;
                end
            end else begin
                lat_cnt++;
            end
        end else begin
            lat_cnt = 0;
        end
    end

    // Issue one access (called just after a rising edge) and hold it until stall drops.
    task automatic access(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] f3);
        bit done;
        done = 1'b0;
        ack_addr_q.delete();
        wr_cnt      = 0;
        acc_stalled = 0;
        acc_rdata   = 32'hXXXXXXXX;
        cpu_bus.req_i    = 1'b1;
        cpu_bus.we_i     = we;
        cpu_bus.addr_i   = addr;
        cpu_bus.wdata_i  = wdata;
        cpu_bus.funct3_i = f3;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            #1;
            if (!cpu_bus.stall_o) begin
                acc_rdata = cpu_bus.rdata_o;
                done = 1'b1;
            end else begin
                acc_stalled++;
            end
        end
        n_cmp++;
        if (!done) begin
            $display("FAIL access_timeout addr=%h: stall_o still 1, required completion", addr);
            n_err++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cpu_bus.req_i = 1'b0; cpu_bus.we_i = 1'b0; cpu_bus.addr_i = 32'h0;
        cpu_bus.wdata_i = 32'h0; cpu_bus.funct3_i = F3_WORD;
        mem_bus.mem_rdata_i = 32'h0;
        rst_ni = 1'b1;
        #1 rst_ni = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (cpu_bus.stall_o !== 1'b0) begin $display("FAIL reset_stall got=%b exp=0", cpu_bus.stall_o); n_err++; end
        n_cmp++; if (mem_bus.mem_req_o !== 1'b0) begin $display("FAIL reset_mem_req got=%b exp=0", mem_bus.mem_req_o); n_err++; end
        n_cmp++; if (mem_bus.mem_we_o !== 1'b0) begin $display("FAIL reset_mem_we got=%b exp=0", mem_bus.mem_we_o); n_err++; end
        n_cmp++; if (cpu_bus.rdata_o !== 32'h0) begin $display("FAIL reset_rdata got=%h exp=0", cpu_bus.rdata_o); n_err++; end
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_refill();
        logic [31:0] a;
        access(1'b0, 32'h40, 32'h0, F3_WORD);
        n_cmp++; if (acc_rdata !== 32'hDEADBEEF) begin $display("FAIL refill_rdata got=%h exp=deadbeef", acc_rdata); n_err++; end
        n_cmp++; if (ack_addr_q.size() !== 4) begin $display("FAIL refill_beats got=%0d exp=4", ack_addr_q.size()); n_err++; end
        for (int i = 0; i < 4; i++) begin
            a = (i < ack_addr_q.size()) ? ack_addr_q[i] : 32'hFFFFFFFF;
            n_cmp++; if (a !== 32'h40 + 32'(4 * i)) begin $display("FAIL refill_addr%0d got=%h exp=%h", i, a, 32'h40 + 32'(4 * i)); n_err++; end
        end
        n_cmp++; if (acc_stalled < 4) begin $display("FAIL refill_stall got=%0d cycles exp>=4", acc_stalled); n_err++; end
        n_cmp++; if (wr_cnt !== 0) begin $display("FAIL refill_writes got=%0d exp=0", wr_cnt); n_err++; end
        access(1'b0, 32'h44, 32'h0, F3_WORD);
        n_cmp++; if (acc_stalled !== 0) begin $display("FAIL hit_stall got=%0d exp=0", acc_stalled); n_err++; end
        n_cmp++; if (acc_rdata !== 32'h11111111) begin $display("FAIL hit_rdata got=%h exp=11111111", acc_rdata); n_err++; end
        n_cmp++; if (ack_addr_q.size() !== 0) begin $display("FAIL hit_beats got=%0d exp=0", ack_addr_q.size()); n_err++; end
        access(1'b0, 32'h4C, 32'h0, 3'b000);
        n_cmp++; if (acc_rdata !== 32'h33333333) begin $display("FAIL other_f3_rdata got=%h exp=33333333", acc_rdata); n_err++; end
        cpu_bus.req_i = 1'b0;
    endtask

    task automatic test_store_word();
        access(1'b1, 32'h48, 32'h12345678, F3_WORD);
        n_cmp++; if (wr_cnt !== 1) begin $display("FAIL sw_writes got=%0d exp=1", wr_cnt); n_err++; end
        n_cmp++; if (last_be !== 4'b1111) begin $display("FAIL sw_be got=%b exp=1111", last_be); n_err++; end
        n_cmp++; if (last_wdata !== 32'h12345678) begin $display("FAIL sw_wdata got=%h exp=12345678", last_wdata); n_err++; end
        n_cmp++; if (mem_q[32'h48] !== 32'h12345678) begin $display("FAIL sw_backing got=%h exp=12345678", mem_q[32'h48]); n_err++; end
        access(1'b0, 32'h48, 32'h0, F3_WORD);
        n_cmp++; if (acc_stalled !== 0) begin $display("FAIL sw_load_stall got=%0d exp=0", acc_stalled); n_err++; end
        n_cmp++; if (acc_rdata !== 32'h12345678) begin $display("FAIL sw_load_rdata got=%h exp=12345678", acc_rdata); n_err++; end
        cpu_bus.req_i = 1'b0;
    endtask

    task automatic test_store_byte();
        access(1'b1, 32'h4A, 32'hFFFFFFAB, F3_BYTE);
        n_cmp++; if (last_be !== 4'b0100) begin $display("FAIL sb_be got=%b exp=0100", last_be); n_err++; end
        n_cmp++; if (last_wdata !== 32'hABABABAB) begin $display("FAIL sb_wdata got=%h exp=abababab", last_wdata); n_err++; end
        n_cmp++; if (ack_addr_q.size() < 1 || ack_addr_q[0] !== 32'h48) begin $display("FAIL sb_addr got=%0d beats exp=1 beat at 00000048", ack_addr_q.size()); n_err++; end
        n_cmp++; if (mem_q[32'h48] !== 32'h12AB5678) begin $display("FAIL sb_backing got=%h exp=12ab5678", mem_q[32'h48]); n_err++; end
        access(1'b0, 32'h4A, 32'h0, F3_BYTE);
        n_cmp++; if (acc_stalled !== 0) begin $display("FAIL lbu_stall got=%0d exp=0", acc_stalled); n_err++; end
        n_cmp++; if (acc_rdata !== 32'h000000AB) begin $display("FAIL lbu_rdata got=%h exp=000000ab", acc_rdata); n_err++; end
        access(1'b0, 32'h48, 32'h0, F3_WORD);
        n_cmp++; if (acc_rdata !== 32'h12AB5678) begin $display("FAIL sb_word_rdata got=%h exp=12ab5678", acc_rdata); n_err++; end
        cpu_bus.req_i = 1'b0;
    endtask

    task automatic test_store_miss();
        access(1'b1, 32'h1000, 32'hCAFEF00D, F3_WORD);
        n_cmp++; if (wr_cnt !== 1) begin $display("FAIL sm_writes got=%0d exp=1", wr_cnt); n_err++; end
        n_cmp++; if (ack_addr_q.size() < 1 || ack_addr_q[0] !== 32'h1000) begin $display("FAIL sm_addr got=%0d beats exp=1 beat at 00001000", ack_addr_q.size()); n_err++; end
        access(1'b0, 32'h1000, 32'h0, F3_WORD);
        n_cmp++; if (ack_addr_q.size() !== 4) begin $display("FAIL sm_refill_beats got=%0d exp=4", ack_addr_q.size()); n_err++; end
        n_cmp++; if (acc_rdata !== 32'hCAFEF00D) begin $display("FAIL sm_rdata got=%h exp=cafef00d", acc_rdata); n_err++; end
        cpu_bus.req_i = 1'b0;
    endtask

    task automatic test_conflict();
        access(1'b0, 32'h40, 32'h0, F3_WORD);
        n_cmp++; if (acc_stalled !== 0) begin $display("FAIL cf_first_stall got=%0d exp=0", acc_stalled); n_err++; end
        access(1'b0, 32'h140, 32'h0, F3_WORD);
        n_cmp++; if (ack_addr_q.size() !== 4) begin $display("FAIL cf_evict_beats got=%0d exp=4", ack_addr_q.size()); n_err++; end
        n_cmp++; if (acc_rdata !== 32'h5A5A0140) begin $display("FAIL cf_evict_rdata got=%h exp=5a5a0140", acc_rdata); n_err++; end
        access(1'b0, 32'h40, 32'h0, F3_WORD);
        n_cmp++; if (ack_addr_q.size() !== 4) begin $display("FAIL cf_reload_beats got=%0d exp=4", ack_addr_q.size()); n_err++; end
        n_cmp++; if (acc_rdata !== 32'hDEADBEEF) begin $display("FAIL cf_reload_rdata got=%h exp=deadbeef", acc_rdata); n_err++; end
        access(1'b0, 32'h48, 32'h0, F3_WORD);
        n_cmp++; if (acc_stalled !== 0) begin $display("FAIL b2b_stall got=%0d exp=0", acc_stalled); n_err++; end
        n_cmp++; if (acc_rdata !== 32'h12AB5678) begin $display("FAIL b2b_rdata got=%h exp=12ab5678", acc_rdata); n_err++; end
        cpu_bus.req_i = 1'b0;
    endtask

    task automatic test_reset_abort();
        bit seen;
        seen = 1'b0;
        ack_addr_q.delete();
        cpu_bus.req_i = 1'b1; cpu_bus.we_i = 1'b0;
        cpu_bus.addr_i = 32'h200; cpu_bus.funct3_i = F3_WORD;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (ack_addr_q.size() >= 2) seen = 1'b1;
        end
        n_cmp++; if (!seen) begin $display("FAIL abort_two_beats got=%0d exp=2", ack_addr_q.size()); n_err++; end
        @(posedge clk);
        #2;
        n_cmp++; if (mem_bus.mem_req_o !== 1'b1) begin $display("FAIL abort_req_before got=%b exp=1", mem_bus.mem_req_o); n_err++; end
        rst_ni = 1'b0;
        #1;
        n_cmp++; if (mem_bus.mem_req_o !== 1'b0) begin $display("FAIL abort_req_async got=%b exp=0", mem_bus.mem_req_o); n_err++; end
        n_cmp++; if (cpu_bus.stall_o !== 1'b0) begin $display("FAIL abort_stall got=%b exp=0", cpu_bus.stall_o); n_err++; end
        cpu_bus.req_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        @(posedge clk);
        #1;
        access(1'b0, 32'h200, 32'h0, F3_WORD);
        n_cmp++; if (ack_addr_q.size() !== 4) begin $display("FAIL abort_refill_beats got=%0d exp=4", ack_addr_q.size()); n_err++; end
        n_cmp++; if (ack_addr_q.size() < 1 || ack_addr_q[0] !== 32'h200) begin $display("FAIL abort_first_addr got=%0d beats exp=first at 00000200", ack_addr_q.size()); n_err++; end
        n_cmp++; if (acc_rdata !== 32'h0BADF00D) begin $display("FAIL abort_rdata got=%h exp=0badf00d", acc_rdata); n_err++; end
        cpu_bus.req_i = 1'b0;
    endtask

    initial begin
        mem_q[32'h40]  = 32'hDEADBEEF;
        mem_q[32'h44]  = 32'h11111111;
        mem_q[32'h48]  = 32'h22222222;
        mem_q[32'h4C]  = 32'h33333333;
        mem_q[32'h140] = 32'h5A5A0140;
        mem_q[32'h200] = 32'h0BADF00D;
        test_reset();
        test_refill();
        test_store_word();
        test_store_byte();
        test_store_miss();
        test_conflict();
        test_reset_abort();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dcache_wt.md
Name: dcache_wt

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Acts as the responder to the pipeline's MEM-stage load/store requests, and as the initiator toward a slower backing word memory.
- Hits return data combinationally in the request cycle.
- Misses and stores assert stall_o, which the hazard logic uses to freeze IF/ID/EX/MEM until the access completes.

Parameters:
- SETS, 16, number of cache lines; power of two.
- LINE_WORDS, 4, 32-bit words per line; power of two, at least 2.
- ADDR_W, 32, byte-address width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  1  CPU access valid (load or store in MEM stage)
- we_i  in  1  1 = store, 0 = load
- addr_i  in  ADDR_W  byte address
- wdata_i  in  32  store data (low byte used for SB)
- funct3_i  in  3  3'b010 = word, 3'b100 = LBU/SB byte; other codes treated as word
- rdata_o  out  32  load result, valid when req_i & ~we_i & ~stall_o
- stall_o  out  1  CPU must hold req_i/addr_i/we_i/wdata_i/funct3_i stable while high
- mem_req_o  out  1  backing-memory request
- mem_we_o  out  1  backing write
- mem_addr_o  out  ADDR_W  word-aligned backing address
- mem_wdata_o  out  32  backing write data
- mem_be_o  out  4  byte enables for backing write
- mem_ack_i  in  1  one-cycle completion pulse
- mem_rdata_i  in  32  read data, valid with mem_ack_i

Behaviour:
- Address split: offset[1:0], word index log2(LINE_WORDS), set index log2(SETS), remaining upper bits form the tag.
- Storage: valid bit per line, tag per line, data array of SETS*LINE_WORDS words (flops).
- Reset (async, rst_ni=0):
  - all valid bits cleared; state=IDLE; refill counter=0.
  - mem_req_o=0, mem_we_o=0, stall_o=0, rdata_o=0.
  - Data/tag contents are don't-care.
  - Reset during REFILL or WRITE aborts the transaction; the line stays invalid.
- Hit = req_i & valid[set] & tag match.
- IDLE:
  - Load hit: stall_o=0; rdata_o = word, or zero-extended byte selected by offset for LBU. Zero latency.
  - Load miss: stall_o=1 in that cycle; go to REFILL; counter=0.
  - Store (hit or miss): stall_o=1; go to WRITE.
  - req_i=0: stall_o=0, rdata_o=0.
- REFILL:
  - mem_req_o=1, mem_we_o=0, mem_addr_o = {tag, set, counter, 2'b00}.
  - Each mem_ack_i: write mem_rdata_i into data[set][counter]; counter++.
  - On the ack with counter==LINE_WORDS-1: set valid, write tag, go to RESP.
  - stall_o=1 throughout.
  - Refill order is always word 0 upward, with no critical-word-first.
  - mem_req_o stays high between beats; the backing memory may take any number of cycles per ack.
- RESP (1 cycle):
  - Line now hits; stall_o=0; rdata_o from cache; return to IDLE.
  - The CPU consumes the load this cycle.
- WRITE:
  - mem_req_o=1, mem_we_o=1, mem_addr_o word-aligned addr_i.
  - mem_be_o = 4'b1111 for word, one-hot by offset for byte.
  - mem_wdata_o = wdata_i for word, or wdata_i[7:0] replicated into all 4 lanes for byte.
  - On mem_ack_i:
    - If hit, update the cached word under the same byte enables; a miss leaves the cache unchanged (no-allocate).
    - stall_o drops that same cycle; go to IDLE.
- Misaligned word access is undefined: the low address bits are ignored.
- mem_ack_i outside REFILL/WRITE is ignored.
- Back-to-back: a new request in the cycle after RESP or write completion is evaluated normally in IDLE.

Decomposition:
- Package dcache_pkg holds:
  - state enum {IDLE, REFILL, RESP, WRITE};
  - funct3 constants F3_WORD=3'b010, F3_BYTE=3'b100;
  - localparam helpers for index/offset widths.
- One sub-module, dcache_store_align: byte-enable and lane-replication generation for stores, plus byte-extract for loads. Purely combinational; reused on both the cache-update and backing-write paths.

Test Plan:
- Reset, then load 0x40 with the backing word at 0x40 = 0xDEADBEEF and ack latency 2: stall_o is high for 4 beats, addresses 0x40,0x44,0x48,0x4C are issued, and RESP returns 0xDEADBEEF. An immediate reload of 0x44 hits with stall_o=0.
- Word store 0x12345678 to 0x48 (line resident): one backing write with be=1111. A subsequent load of 0x48 hits and returns 0x12345678.
- SB 0xAB to 0x4A (hit): mem_be_o=0100, mem_wdata_o=0xABABABAB. Then LBU 0x4A returns 0x000000AB and a word load of 0x48 returns 0x12AB5678.
- Store to uncached 0x1000: a backing write is issued and the line stays invalid. A load of 0x1000 then misses and refills.
- Conflict: load 0x40, then load 0x40+SETS*LINE_WORDS*4 (same set, different tag) misses and evicts. Reloading 0x40 misses again.
- Assert rst_ni=0 after the 2nd refill beat: mem_req_o drops asynchronously. After release, a load of the same address misses and does a full 4-beat refill.
